// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: requester-side controller for a single-port SRAM wrapper.
// After reset (or a flush) it sweeps every address, writing INIT_VAL. It then
// serves a valid/ready request stream and returns read data on a valid/ready
// response channel. A one-entry hold register keeps read data that arrives
// while the consumer is stalled.
// Optional feature macro: SRAM_INIT_SWEEP_EN. When it is defined, the init
// sweep and flush are enabled. When it is undefined, the controller starts
// directly in RUN and ignores flush.
module sram_req_ctrl #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 8,
  parameter int                MASK_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data,
  output logic [MASK_W-1:0] sram_w_mask,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_e;

`ifdef SRAM_INIT_SWEEP_EN
  localparam logic   SweepEn    = 1'b1;
  localparam state_e ResetState = INIT;
`else
  localparam logic   SweepEn    = 1'b0;
  localparam state_e ResetState = RUN;
`endif

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] OneAddr  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                inRun;
  logic                accept;

  // Next-state and output decode: sweep writes in INIT, request handling in RUN,
  // response/hold management in both states so in-flight reads always complete.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_pend_d    = 1'b0;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;

    inRun      = reset && (state_q == RUN);
    init_done  = inRun;
    req_ready  = inRun && !hold_valid_q && !(rd_pend_q && !resp_ready);
    accept     = req_valid && req_ready;
    resp_valid = reset && (rd_pend_q || hold_valid_q);
    resp_rdata = hold_valid_q ? hold_q : sram_r_data;

    sram_r_addr = req_addr;
    sram_w_en   = 1'b0;
    sram_w_addr = req_addr;
    sram_w_data = req_wdata;
    sram_w_mask = req_wmask;

    if (state_q == INIT) begin
      sram_w_en   = reset;
      sram_w_addr = cnt_q;
      sram_w_data = INIT_VAL;
      sram_w_mask = {MASK_W{1'b1}};
      cnt_d       = cnt_q + OneAddr;
      if (cnt_q == LastAddr) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      sram_w_en = accept && req_wen;
      if (flush && SweepEn) begin
        state_d = INIT;
        cnt_d   = '0;
      end
    end

    rd_pend_d = accept && !req_wen;

    if (rd_pend_q && !resp_ready) begin
      hold_valid_d = 1'b1;
      hold_d       = sram_r_data;
    end else if (hold_valid_q && resp_ready) begin
      hold_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset; pending reads are dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ResetState;
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= rd_pend_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Testbench for sram_req_ctrl: behavioural SRAM model, a table of per-cycle
// request vectors with hand-computed expectations, and hand-written sequences
// for sweep, backpressure, flush and reset corner cases. Sweep-specific checks
// follow the SRAM_INIT_SWEEP_EN macro.
module tb_sram_req_ctrl;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic       req_wen;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic [3:0] req_wmask;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_rdata;
  logic [5:0] sram_r_addr;
  logic [7:0] sram_r_data;
  logic       sram_w_en;
  logic [5:0] sram_w_addr;
  logic [7:0] sram_w_data;
  logic [3:0] sram_w_mask;
  logic       init_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [64];

  sram_req_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr),
    .sram_w_data(sram_w_data), .sram_w_mask(sram_w_mask),
    .init_done(init_done)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM wrapper model: masked write has priority, otherwise 1-cycle read.
  always @(posedge clock) begin
    if (sram_w_en) begin
      for (int i = 0; i < 4; i++)
        if (sram_w_mask[i]) mem[sram_w_addr][2*i +: 2] <= sram_w_data[2*i +: 2];
    end else begin
      sram_r_data <= mem[sram_r_addr];
    end
  end

  typedef struct {
    logic       v;
    logic       wen;
    logic [5:0] addr;
    logic [7:0] wd;
    logic [3:0] wm;
    logic       rr;
    logic       eRdy;
    logic       eRv;
    logic [7:0] eRd;
    logic       eWen;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic v, logic wen, logic [5:0] addr, logic [7:0] wd,
                              logic [3:0] wm, logic rr, logic eRdy, logic eRv,
                              logic [7:0] eRd, logic eWen);
    vec_t r;
    r.v = v; r.wen = wen; r.addr = addr; r.wd = wd; r.wm = wm; r.rr = rr;
    r.eRdy = eRdy; r.eRv = eRv; r.eRd = eRd; r.eWen = eWen;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; return at the falling edge.
  task automatic applyStimulus(input logic v, input logic wen, input logic [5:0] addr,
                               input logic [7:0] wd, input logic [3:0] wm,
                               input logic rr, input logic fl);
    @(posedge clock);
    #1;
    req_valid  = v;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wd;
    req_wmask  = wm;
    resp_ready = rr;
    flush      = fl;
    @(negedge clock);
  endtask

  task automatic runVector(input int idx);
    vec_t t;
    t = vecs[idx];
    applyStimulus(t.v, t.wen, t.addr, t.wd, t.wm, t.rr, 1'b0);
    checkOutput($sformatf("vec%0d_req_ready", idx), 32'(req_ready), 32'(t.eRdy));
    checkOutput($sformatf("vec%0d_resp_valid", idx), 32'(resp_valid), 32'(t.eRv));
    checkOutput($sformatf("vec%0d_w_en", idx), 32'(sram_w_en), 32'(t.eWen));
    if (t.eRv)
      checkOutput($sformatf("vec%0d_resp_rdata", idx), 32'(resp_rdata), 32'(t.eRd));
    if (t.eWen)
      checkOutput($sformatf("vec%0d_w_addr", idx), 32'(sram_w_addr), 32'(t.addr));
  endtask

  // Observe sweep writes at each falling edge until init_done rises (bounded).
  task automatic runSweep(input int start, output int n, output int errs);
    bit done;
    int a;
    done = 1'b0;
    n    = 0;
    errs = 0;
    a    = start;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (init_done) begin
        done = 1'b1;
      end else begin
        if (!(sram_w_en && sram_w_addr == 6'(a) && sram_w_data == 8'h00 && sram_w_mask == 4'hF))
          errs++;
        n++;
        a++;
      end
    end
  endtask

  logic [7:0] initExp;
  logic [7:0] held;
  int         n;
  int         errs;

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 8'(a) ^ 8'h5A;
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;

`ifdef SRAM_INIT_SWEEP_EN
    initExp = 8'h00;
`else
    initExp = 8'h70;
`endif

    vecs[0]  = mk(1, 1, 6'h01, 8'h11, 4'hF, 1, 1, 0, 8'h00, 1);
    vecs[1]  = mk(1, 1, 6'h02, 8'h22, 4'hF, 1, 1, 0, 8'h00, 1);
    vecs[2]  = mk(1, 1, 6'h03, 8'h33, 4'hF, 1, 1, 0, 8'h00, 1);
    vecs[3]  = mk(1, 1, 6'h05, 8'hA5, 4'hF, 1, 1, 0, 8'h00, 1);
    vecs[4]  = mk(1, 0, 6'h05, 8'h00, 4'h0, 1, 1, 0, 8'h00, 0);
    vecs[5]  = mk(1, 0, 6'h01, 8'h00, 4'h0, 1, 1, 1, 8'hA5, 0);
    vecs[6]  = mk(1, 0, 6'h02, 8'h00, 4'h0, 1, 1, 1, 8'h11, 0);
    vecs[7]  = mk(1, 0, 6'h03, 8'h00, 4'h0, 1, 1, 1, 8'h22, 0);
    vecs[8]  = mk(0, 0, 6'h00, 8'h00, 4'h0, 1, 1, 1, 8'h33, 0);
    vecs[9]  = mk(0, 0, 6'h00, 8'h00, 4'h0, 1, 1, 0, 8'h00, 0);
    vecs[10] = mk(1, 1, 6'h07, 8'hFF, 4'hF, 1, 1, 0, 8'h00, 1);
    vecs[11] = mk(1, 1, 6'h07, 8'h00, 4'h5, 1, 1, 0, 8'h00, 1);
    vecs[12] = mk(1, 0, 6'h07, 8'h00, 4'h0, 1, 1, 0, 8'h00, 0);
    vecs[13] = mk(1, 0, 6'h2A, 8'h00, 4'h0, 0, 0, 1, 8'hCC, 0);
    vecs[14] = mk(1, 0, 6'h2A, 8'h00, 4'h0, 0, 0, 1, 8'hCC, 0);
    vecs[15] = mk(1, 0, 6'h2A, 8'h00, 4'h0, 0, 0, 1, 8'hCC, 0);
    vecs[16] = mk(1, 0, 6'h2A, 8'h00, 4'h0, 1, 0, 1, 8'hCC, 0);
    vecs[17] = mk(1, 0, 6'h2A, 8'h00, 4'h0, 1, 1, 0, 8'h00, 0);
    vecs[18] = mk(0, 0, 6'h00, 8'h00, 4'h0, 1, 1, 1, initExp, 0);
    vecs[19] = mk(0, 0, 6'h00, 8'h00, 4'h0, 1, 1, 0, 8'h00, 0);
    vecs[20] = mk(1, 0, 6'h05, 8'h00, 4'h0, 1, 1, 0, 8'h00, 0);
    vecs[21] = mk(1, 1, 6'h06, 8'h66, 4'hF, 1, 1, 1, 8'hA5, 1);
    vecs[22] = mk(0, 0, 6'h00, 8'h00, 4'h0, 1, 1, 0, 8'h00, 0);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_w_en", 32'(sram_w_en), 32'd0);
    reset = 1'b1;

`ifdef SRAM_INIT_SWEEP_EN
    runSweep(0, n, errs);
    checkOutput("sweep_len", 32'(n), 32'd64);
    checkOutput("sweep_writes", 32'(errs), 32'd0);
`else
    @(negedge clock);
    checkOutput("first_init_done", 32'(init_done), 32'd1);
    checkOutput("first_req_ready", 32'(req_ready), 32'd1);
    checkOutput("first_w_en", 32'(sram_w_en), 32'd0);
`endif

    for (int i = 0; i < 23; i++) runVector(i);

    // Flush with a read in flight; the response is held and delivered across the flush.
    applyStimulus(1, 0, 6'h05, 8'h00, 4'h0, 1, 0);
    checkOutput("fl_accept", 32'(req_ready), 32'd1);
    applyStimulus(0, 0, 6'h00, 8'h00, 4'h0, 0, 1);
    checkOutput("fl_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("fl_resp_rdata", 32'(resp_rdata), 32'hA5);
    applyStimulus(0, 0, 6'h00, 8'h00, 4'h0, 0, 0);
    held = resp_rdata;
    checkOutput("fl_hold_valid", 32'(resp_valid), 32'd1);
    checkOutput("fl_hold_rdata", 32'(held), 32'hA5);
    checkOutput("fl_hold_ready", 32'(req_ready), 32'd0);
`ifdef SRAM_INIT_SWEEP_EN
    checkOutput("fl_init_done", 32'(init_done), 32'd0);
    checkOutput("fl_w_en", 32'(sram_w_en), 32'd1);
    checkOutput("fl_w_addr", 32'(sram_w_addr), 32'd0);
`else
    checkOutput("fl_init_done", 32'(init_done), 32'd1);
    checkOutput("fl_w_en", 32'(sram_w_en), 32'd0);
`endif
    applyStimulus(0, 0, 6'h00, 8'h00, 4'h0, 1, 0);
    checkOutput("fl_drain_valid", 32'(resp_valid), 32'd1);
    checkOutput("fl_drain_rdata", 32'(resp_rdata), 32'hA5);
`ifdef SRAM_INIT_SWEEP_EN
    runSweep(2, n, errs);
    checkOutput("fl_sweep_len", 32'(n), 32'd62);
    checkOutput("fl_sweep_writes", 32'(errs), 32'd0);
`endif
    applyStimulus(0, 0, 6'h00, 8'h00, 4'h0, 1, 0);
    checkOutput("fl_after_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("fl_after_ready", 32'(req_ready), 32'd1);
    applyStimulus(1, 0, 6'h05, 8'h00, 4'h0, 1, 0);
    applyStimulus(0, 0, 6'h00, 8'h00, 4'h0, 1, 0);
    checkOutput("fl_reread_valid", 32'(resp_valid), 32'd1);
`ifdef SRAM_INIT_SWEEP_EN
    checkOutput("fl_reread_rdata", 32'(resp_rdata), 32'h00);
`else
    checkOutput("fl_reread_rdata", 32'(resp_rdata), 32'hA5);
`endif

    // Reset with a read pending discards it.
    applyStimulus(1, 0, 6'h02, 8'h00, 4'h0, 1, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("rr_resp_valid_in_rst", 32'(resp_valid), 32'd0);
    checkOutput("rr_w_en_in_rst", 32'(sram_w_en), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rr_resp_valid_after", 32'(resp_valid), 32'd0);
`ifdef SRAM_INIT_SWEEP_EN
    checkOutput("rr_init_done_after", 32'(init_done), 32'd0);
    // Reset again at sweep cycle 30: the sweep restarts from address 0.
    repeat (29) @(negedge clock);
    checkOutput("ms_addr29", 32'(sram_w_addr), 32'd29);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("ms_init_done_in_rst", 32'(init_done), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    runSweep(0, n, errs);
    checkOutput("ms_sweep_len", 32'(n), 32'd64);
    checkOutput("ms_sweep_writes", 32'(errs), 32'd0);
`else
    checkOutput("rr_init_done_after", 32'(init_done), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
